// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store unit: size and state encodings,
// sub-word extraction with sign/zero extension, and sub-word merge into a RAM word.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_MERGE  = 2'b10
   } state_e;

   function automatic logic is_misaligned(input size_e size, input logic [1:0] lane);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = lane[0];
         SZ_WORD: bad = (lane != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Little-endian lanes: byte at offset 0 lives in bits [7:0].
   function automatic logic [31:0] lane_extract(input logic [31:0] word, input size_e size,
                                                input logic [1:0] lane, input logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: r = {{24{sgn & b[7]}}, b};
         SZ_HALF: r = {{16{sgn & h[15]}}, h};
         SZ_WORD: r = word;
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [15:0] wdata,
                                              input size_e size, input logic [1:0] lane);
      logic [31:0] r;
      r = word;
      case (size)
         SZ_BYTE: begin
            case (lane)
               2'd0:    r[7:0]   = wdata[7:0];
               2'd1:    r[15:8]  = wdata[7:0];
               2'd2:    r[23:16] = wdata[7:0];
               default: r[31:24] = wdata[7:0];
            endcase
         end
         SZ_HALF: begin
            if (lane[1]) r[31:16] = wdata;
            else         r[15:0]  = wdata;
         end
         default: r = word;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend from the RAM word and
// sub-word store merge into the captured word.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [31:0] rd_word,
   input  logic [31:0] mrg_word,
   input  logic [15:0] wdata,
   input  size_e       size,
   input  logic [1:0]  lane,
   input  logic        sgn,
   output logic [31:0] ld_data,
   output logic [31:0] st_data
);

   assign ld_data = lane_extract(rd_word, size, lane, sgn);
   assign st_data = lane_merge(mrg_word, wdata, size, lane);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, word-aligned RAM accesses, sub-word
// stores via read-modify-write, misaligned requests answered without touching RAM.
module load_store_unit #(
   parameter int MEM_DEPTH  = 1024,
   parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_store,
   input  logic [1:0]            req_size,
   input  logic                  req_signed,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_misaligned,
   output logic [ADDR_WIDTH-1:0] mem_A,
   output logic                  mem_WE,
   output logic [31:0]           mem_WD,
   input  logic [31:0]           mem_RD
);
   import lsu_pkg::*;

   state_e                state_q, state_d;
   logic                  store_q, store_d;
   size_e                 size_q, size_d;
   logic                  signed_q, signed_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  err_q, err_d;
   logic [31:0]           merge_q, merge_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [31:0]           rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_mis_q, rsp_mis_d;
   logic [31:0]           ld_data;
   logic [31:0]           st_data;

   lsu_align u_align (
      .rd_word  (mem_RD),
      .mrg_word (merge_q),
      .wdata    (wdata_q[15:0]),
      .size     (size_q),
      .lane     (addr_q[1:0]),
      .sgn      (signed_q),
      .ld_data  (ld_data),
      .st_data  (st_data)
   );

   assign req_ready      = (state_q == ST_IDLE);
   assign mem_A          = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign rsp_valid      = rsp_valid_q;
   assign rsp_rdata      = rsp_rdata_q;
   assign rsp_misaligned = rsp_mis_q;

   always_comb begin
      state_d     = state_q;
      store_d     = store_q;
      size_d      = size_q;
      signed_d    = signed_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      err_d       = err_q;
      merge_d     = merge_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = '0;
      rsp_mis_d   = 1'b0;
      mem_WE      = 1'b0;
      mem_WD      = '0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               store_d  = req_store;
               size_d   = size_e'(req_size);
               signed_d = req_signed;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               err_d    = is_misaligned(size_e'(req_size), req_addr[1:0]);
               state_d  = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (err_q) begin
               rsp_valid_d = 1'b1;
               rsp_mis_d   = 1'b1;
               state_d     = ST_IDLE;
            end else if (!store_q) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = ld_data;
               state_d     = ST_IDLE;
            end else if (size_q == SZ_WORD) begin
               mem_WE      = 1'b1;
               mem_WD      = wdata_q;
               rsp_valid_d = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               // Sub-word store: read phase of the read-modify-write.
               merge_d = mem_RD;
               state_d = ST_MERGE;
            end
         end
         ST_MERGE: begin
            mem_WE      = 1'b1;
            mem_WD      = st_data;
            rsp_valid_d = 1'b1;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= ST_IDLE;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_mis_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_mis_q   <= rsp_mis_d;
      end
   end

   // Request fields are only consumed after an accept, so they carry no reset.
   always_ff @(posedge CLK) begin
      store_q  <= store_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      merge_q  <= merge_d;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the MIPS datapath and the byte-addressable data RAM. Accepts one load/store request at a time and converts byte, halfword and word accesses into aligned 32-bit RAM accesses. Loads are extracted and sign- or zero-extended. Sub-word stores use a read-modify-write sequence, because the RAM only writes whole words. Misaligned requests produce an error response and never touch memory.

## Interface
- `MEM_DEPTH`, default 1024: RAM depth in bytes. Must be a power of 2 and ≥ 4.
- `ADDR_WIDTH`, default `$clog2(MEM_DEPTH)`: byte-address width.
- `CLK`, in, 1: single clock; all state changes on the rising edge.
- `RST_N`, in, 1: reset, asynchronous, active-low.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: high only in IDLE. A request is accepted on an edge where `req_valid && req_ready`.
- `req_store`, in, 1: 1 = store, 0 = load.
- `req_size`, in, 2: access size. 00 = byte, 01 = half, 10 = word, 11 = reserved.
- `req_signed`, in, 1: sign-extend a load (lb/lh). Ignored for stores and word loads.
- `req_addr`, in, `ADDR_WIDTH`: byte address.
- `req_wdata`, in, 32: store data, taken from the low-order bits.
- `rsp_valid`, out, 1: registered one-cycle completion pulse. There is no backpressure.
- `rsp_rdata`, out, 32: load result. Valid while `rsp_valid` is high; 0 for stores and errors.
- `rsp_misaligned`, out, 1: error flag. Valid while `rsp_valid` is high.
- `mem_A`, out, `ADDR_WIDTH`: word-aligned RAM address, always `{addr[ADDR_WIDTH-1:2], 2'b00}`.
- `mem_WE`, out, 1: RAM write enable.
- `mem_WD`, out, 32: RAM write data.
- `mem_RD`, in, 32: RAM read data, combinational from `mem_A`. Little-endian: byte at A is bits [7:0].

## Operation
- **States:** IDLE, ACCESS, MERGE.
- **Accept (IDLE):** on an accept edge, register store, size, signed, addr and wdata, plus `err`. Next state is ACCESS.
- **Error condition:** `err` = (size==01 && addr[0]) || (size==10 && addr[1:0]!=0) || size==11.
- **ACCESS:**
  - `mem_A` is driven from the registered address.
  - err: `mem_WE`=0. Next edge sets `rsp_valid`=1, `rsp_misaligned`=1, `rsp_rdata`=0. Back to IDLE.
  - Load: next edge registers the extracted value into `rsp_rdata` and pulses `rsp_valid`. Back to IDLE.
    - Byte lane = addr[1:0].
    - Half lane = addr[1].
    - Extension: sign-extend if `req_signed`, else zero-extend.
  - Word store: `mem_WE`=1, `mem_WD`=wdata. Next edge pulses `rsp_valid`. Back to IDLE.
  - Byte/half store: `mem_WE`=0. Next edge captures `mem_RD` into a merge register. Next state is MERGE.
- **MERGE:**
  - `mem_WE`=1.
  - `mem_WD` = captured word with the target lane replaced by wdata[7:0] or wdata[15:0]. Other bytes are unchanged.
  - Next edge pulses `rsp_valid`. Back to IDLE.
- **Outside write states:** `mem_WE` is 0 in IDLE and in any state not listed as writing. `mem_WD` = 0 when `mem_WE` = 0.
- **Busy:** `req_valid` while not IDLE is ignored. The requester holds its signals until accepted.

## Timing
- **Reset values:** state = IDLE, `rsp_valid`=0, `rsp_rdata`=0, `rsp_misaligned`=0.
- **Reset-derived outputs:** `mem_WE`=0 and `req_ready`=1 follow immediately from IDLE.
- **Latency** (accept edge E0 → `rsp_valid` high in the cycle after the edge shown):
  - Loads, word stores and errors: E1.
  - Byte/half stores: E2.
- **Throughput:** `req_ready` is high in the same cycle as `rsp_valid`, so a new request can be accepted on the edge that ends the response cycle.
  - Back-to-back loads: one every 2 cycles.
  - Sub-word stores: one every 3 cycles.
- **RAM write timing:** the RAM write commits on the edge ending ACCESS (word) or MERGE (sub-word).
- **Reset mid-operation:** `RST_N` low forces IDLE asynchronously and drops `mem_WE` at once. A pending RMW is abandoned with no partial write and no response.
- **Top of memory:** addr = `MEM_DEPTH-1` is legal for a byte access. The aligned word never wraps past `MEM_DEPTH-1`.

## Structure
- **Package `lsu_pkg`:**
  - Size enum: `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`, `SZ_RSVD`.
  - State enum: `ST_IDLE`, `ST_ACCESS`, `ST_MERGE`.
  - Lane-extract and lane-merge functions.
- **Sub-module `lsu_align`:** purely combinational load extract/extend and store merge, used by the FSM top.

## Test plan
- **Word store/load:** sw 0xDEADBEEF @0x10, then lw @0x10. RAM bytes 0x10..0x13 = EF,BE,AD,DE. `rsp_rdata`=0xDEADBEEF at E1, `rsp_misaligned`=0.
- **Byte loads:** after the word store above:
  - lb @0x13 → 0xFFFFFFDE.
  - lbu @0x13 → 0x000000DE.
  - lh @0x12 → 0xFFFFDEAD.
  - lhu @0x10 → 0x0000BEEF.
- **Sub-word RMW:**
  - sb 0x55 @0x11: `mem_WE` is high only in the MERGE cycle, `mem_WD`=0xDEAD55EF, and `rsp_valid` arrives at E2.
  - Then sh 0x1234 @0x12. A following lw returns 0x123455EF.
- **Misaligned:** lw @0x12, sh @0x11 and size=11 each give `rsp_misaligned`=1 and `rsp_rdata`=0 at E1. `mem_WE` never rises and RAM is unchanged.
- **Reset mid-RMW:** drop `RST_N` during MERGE of sb 0xAA @0x20 (word previously 0x11223344). The word stays 0x11223344, no `rsp_valid` appears, and `req_ready`=1 right after reset.
- **Busy/back-to-back:** hold `req_valid` high with two loads. The second is accepted on the edge after the first `rsp_valid` cycle begins, and no request is lost or duplicated.
